dump_stage: RTL

- Third pipeline stage of the SHAKE/SHA3 core, directly downstream of the permute stage.
- Captures one squeezed rate block from the permute stage and serialises it into 64-bit words on a valid/ready output stream.
- Truncates the stream to the requested output length and signals the final word of each message.
- Owns the output_buffer_available flag that the permute stage polls and clears.

---
 rtl/keccak_pkg_mine.sv | 35 +++
 rtl/dump_datapath.sv | 93 +++++++++
 rtl/dump_fsm.sv | 70 +++++++
 rtl/dump_stage.sv | 62 ++++++
 4 files changed

// File: rtl/keccak_pkg_mine.sv
// Shared definitions for the SHAKE/SHA3 core: rate widths, mode encoding,
// FSM state type for the dump stage and the mode-to-words helper.
package keccak_pkg_mine;

  localparam int WORD_W        = 64;
  localparam int RATE_SHAKE128 = 1344;
  localparam int RATE_SHAKE256 = 1088;
  localparam int RATE_SHA3_256 = 1088;
  localparam int RATE_SHA3_512 = 576;
  localparam int IDX_W         = 5;

  typedef enum logic [1:0] {
    MODE_SHAKE128 = 2'b00,
    MODE_SHAKE256 = 2'b01,
    MODE_SHA3_256 = 2'b10,
    MODE_SHA3_512 = 2'b11
  } op_mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DUMP = 1'b1
  } dump_state_t;

  // Number of 64-bit rate words carried by one squeezed block of a mode.
  function automatic logic [IDX_W-1:0] rate_words(input op_mode_t mode);
    case (mode)
      MODE_SHAKE128: rate_words = IDX_W'(RATE_SHAKE128 / WORD_W);
      MODE_SHAKE256: rate_words = IDX_W'(RATE_SHAKE256 / WORD_W);
      MODE_SHA3_256: rate_words = IDX_W'(RATE_SHA3_256 / WORD_W);
      MODE_SHA3_512: rate_words = IDX_W'(RATE_SHA3_512 / WORD_W);
      default:       rate_words = IDX_W'(RATE_SHAKE128 / WORD_W);
    endcase
  endfunction

endpackage

// File: rtl/dump_datapath.sv
// Data side of the dump stage: captured block and context, word index,
// remaining-bit counter and the registered, masked output word.
module dump_datapath import keccak_pkg_mine::*; #(
  parameter int RATE_W = RATE_SHAKE128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RATE_W-1:0] rate_input,
  input  logic [1:0]        operation_mode_in,
  input  logic [31:0]       output_size_in,
  input  logic              last_output_block_wr,
  input  logic              capture,
  input  logic              load_size,
  input  logic              accept,
  input  logic              dump_next,
  output logic [63:0]       data_out,
  output logic              data_out_last,
  output logic              block_end,
  output logic              size_zero
);

  localparam int NWORDS = RATE_W / WORD_W;

  logic [RATE_W-1:0] block_q;
  logic [RATE_W-1:0] block_d;
  op_mode_t          mode_q;
  op_mode_t          mode_d;
  logic              last_block_q;
  logic              last_block_d;
  logic [IDX_W-1:0]  index_q;
  logic [IDX_W-1:0]  index_d;
  logic [IDX_W-1:0]  words_d;
  logic [IDX_W-1:0]  sel;
  logic [31:0]       remaining_q;
  logic [31:0]       remaining_d;
  logic [31:0]       consumed;
  logic [WORD_W-1:0] words [NWORDS];
  logic [WORD_W-1:0] word_raw;
  logic [WORD_W-1:0] word_mask;

  // Values the context and counters take at the next edge; the output word is built from these.
  always_comb begin
    block_d      = capture ? rate_input : block_q;
    mode_d       = capture ? op_mode_t'(operation_mode_in) : mode_q;
    last_block_d = capture ? last_output_block_wr : last_block_q;
    consumed     = (remaining_q >= 32'd64) ? 32'd64 : remaining_q;
    remaining_d  = remaining_q;
    index_d      = index_q;
    if (load_size)   remaining_d = output_size_in;
    else if (accept) remaining_d = remaining_q - consumed;
    if (capture)     index_d = '0;
    else if (accept) index_d = index_q + 1'b1;
    words_d = rate_words(mode_d);
    sel     = (index_d < words_d) ? index_d : '0;
  end

  for (genvar k = 0; k < NWORDS; k++) begin : g_words
    assign words[k] = block_d[k*WORD_W +: WORD_W];
  end

  // Word selection and tail masking: only the low 'remaining' bits survive in a short final word.
  always_comb begin
    word_raw  = words[sel];
    word_mask = (remaining_d >= 32'd64) ? '1 : ~({WORD_W{1'b1}} << remaining_d[5:0]);
  end

  // Context, counters and the registered output word; data_out is zero whenever nothing is offered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      block_q       <= '0;
      mode_q        <= MODE_SHAKE128;
      last_block_q  <= 1'b0;
      index_q       <= '0;
      remaining_q   <= '0;
      data_out      <= '0;
      data_out_last <= 1'b0;
    end else begin
      block_q       <= block_d;
      mode_q        <= mode_d;
      last_block_q  <= last_block_d;
      index_q       <= index_d;
      remaining_q   <= remaining_d;
      data_out      <= dump_next ? (word_raw & word_mask) : '0;
      data_out_last <= dump_next &&
                       ((remaining_d <= 32'd64) ||
                        (last_block_d && (index_d == words_d - 1'b1)));
    end
  end

  assign block_end = (index_q == rate_words(mode_q) - 1'b1);
  assign size_zero = (output_size_in == 32'd0);

endmodule

// File: rtl/dump_fsm.sv
// Control for the dump stage: IDLE/DUMP sequencing, the valid/ready
// handshake, message tracking and the buffer-available flag.
module dump_fsm import keccak_pkg_mine::*; (
  input  logic clk,
  input  logic rst,
  input  logic output_buffer_we,
  input  logic output_buffer_available_clr,
  input  logic data_out_ready,
  input  logic word_last,
  input  logic block_end,
  input  logic size_zero,
  output logic output_buffer_available,
  output logic data_out_valid,
  output logic capture,
  output logic load_size,
  output logic accept,
  output logic dump_next
);

  dump_state_t state;
  dump_state_t state_next;
  logic        in_message;
  logic        start_empty;
  logic        block_done;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next state: a zero-length first block never enters DUMP; a block ends on its last word or last rate word.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (output_buffer_we && !start_empty) state_next = ST_DUMP;
      ST_DUMP: if (block_done) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Handshake and strobes derived from the current state; writes outside IDLE are ignored.
  always_comb begin
    data_out_valid = (state == ST_DUMP);
    capture        = (state == ST_IDLE) && output_buffer_we;
    load_size      = capture && !in_message;
    start_empty    = !in_message && size_zero;
    accept         = data_out_valid && data_out_ready;
    block_done     = accept && (word_last || block_end);
    dump_next      = (state_next == ST_DUMP);
  end

  // Message membership and buffer availability; a claim from the permute stage beats a release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_message              <= 1'b0;
      output_buffer_available <= 1'b1;
    end else begin
      if (load_size)
        in_message <= !size_zero;
      else if (block_done && word_last)
        in_message <= 1'b0;
      if (output_buffer_available_clr)
        output_buffer_available <= 1'b0;
      else if (block_done || (capture && start_empty))
        output_buffer_available <= 1'b1;
    end
  end

endmodule

// File: rtl/dump_stage.sv
// Output stage of the SHAKE/SHA3 core: takes one squeezed rate block from
// the permute stage and streams it out as truncated 64-bit words.
module dump_stage import keccak_pkg_mine::*; #(
  parameter int RATE_W = RATE_SHAKE128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RATE_W-1:0] rate_input,
  input  logic [1:0]        operation_mode_in,
  input  logic [31:0]       output_size_in,
  input  logic              output_buffer_we,
  input  logic              last_output_block_wr,
  input  logic              output_buffer_available_clr,
  output logic              output_buffer_available,
  output logic [63:0]       data_out,
  output logic              data_out_valid,
  input  logic              data_out_ready,
  output logic              data_out_last
);

  logic capture;
  logic load_size;
  logic accept;
  logic dump_next;
  logic block_end;
  logic size_zero;

  dump_fsm u_fsm (
    .clk                         (clk),
    .rst                         (rst),
    .output_buffer_we            (output_buffer_we),
    .output_buffer_available_clr (output_buffer_available_clr),
    .data_out_ready              (data_out_ready),
    .word_last                   (data_out_last),
    .block_end                   (block_end),
    .size_zero                   (size_zero),
    .output_buffer_available     (output_buffer_available),
    .data_out_valid              (data_out_valid),
    .capture                     (capture),
    .load_size                   (load_size),
    .accept                      (accept),
    .dump_next                   (dump_next)
  );

  dump_datapath #(.RATE_W(RATE_W)) u_datapath (
    .clk                  (clk),
    .rst                  (rst),
    .rate_input           (rate_input),
    .operation_mode_in    (operation_mode_in),
    .output_size_in       (output_size_in),
    .last_output_block_wr (last_output_block_wr),
    .capture              (capture),
    .load_size            (load_size),
    .accept               (accept),
    .dump_next            (dump_next),
    .data_out             (data_out),
    .data_out_last        (data_out_last),
    .block_end            (block_end),
    .size_zero            (size_zero)
  );

endmodule
